led_pattern_ctrl: RTL
=====================

# led_pattern_ctrl

Sequencer for the 8-LED display. Holds a programmable tick prescaler, a run/step control and a four-mode pattern engine: bounce (staircase), chase, bar fill and blink. It drives `led` directly and replaces free-running pattern logic that has no reset. It sits between the board-level controls (switches/buttons, already debounced) and the LED pins.

## Interface
- `DIV_W`, 8: width of the prescaler divide value and counter.
- `DEFAULT_DIV`, 4: divide value loaded at reset; must be 1..2^DIV_W-1.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level: 1 = free-run on prescaler ticks, 0 = paused.
- `step`  in  1  single-cycle pulse: advance one pattern step while paused.
- `mode`  in  2  pattern select: 0 bounce, 1 chase, 2 fill, 3 blink.
- `div_load`  in  1  single-cycle pulse: load `div_val` into the divide register.
- `div_val`  in  DIV_W  new divide value.
- `led`  out  8  registered LED pattern.
- `tick`  out  1  registered pulse, high one cycle after each pattern advance.
- `wrap`  out  1  registered pulse marking pattern-cycle completion (see Configuration).

## Operation
- Divide register `div_q`:
  - reset value DEFAULT_DIV;
  - on `div_load`, `div_q` <= `div_val`, except 0, which is stored as 1.
- Prescaler `cnt`, reset 0:
  - when `run`=1, `cnt` increments each cycle;
  - when `cnt`==`div_q`-1, an internal advance fires and `cnt` <= 0;
  - when `run`=0, `cnt` holds.
- While `run`=0, `step`=1 fires an advance that cycle; `cnt` is unchanged. `step` is ignored while `run`=1.
- Restart conditions:
  - `mode_q` holds the last sampled mode, reset 0;
  - if `mode` != `mode_q`, `mode_q` <= `mode`, the pattern state resets to the new mode's initial state and `cnt` <= 0;
  - no advance occurs that cycle.
- Priority, highest first: mode restart, `div_load` (which clears `cnt` and suppresses the advance that cycle), advance.
- Pattern state is `pos` (4 bits) plus `dir` (1 bit), both reset 0.
  - Bounce: `led` = 8'h80 >> `pos`. `dir`=0 increments `pos` and `dir`=1 decrements it. At `pos`==7 with `dir`=0, next is `pos`=6, `dir`=1. At `pos`==0 with `dir`=1, next is `pos`=1, `dir`=0. Period is 14 advances: 80,40,…,01,02,…,40,80.
  - Chase: `led` = 8'h80 >> `pos`; `pos` increments modulo 8 (01 -> 80).
  - Fill: `led` = ~(8'hFF >> `pos`); `pos` goes 0..8 then back to 0 (00,80,C0,…,FF,00). Period is 9.
  - Blink: `led` = `pos`[0] ? 8'hFF : 8'h00; `pos`[0] toggles.
- `led` is recomputed from the next state and registered.

## Timing
- Reset values: `led`=8'h80 (bounce, `pos` 0), `tick`=0, `wrap`=0, `cnt`=0, `div_q`=DEFAULT_DIV.
- Asynchronous assertion clears all state immediately, mid-pattern included. Release takes effect on the first `clk` edge after deassertion.
- Advance in cycle N: `led` shows the new pattern and `tick`=1 after edge N; one cycle of latency.
- With `run` held high, advances occur every `div_q` cycles. The first advance occurs `div_q` cycles after `run` rises from a cleared `cnt`.
- `div_q`=1: an advance every cycle.
- Mode restart in cycle N: `led` shows the new mode's initial pattern after edge N (bounce/chase 80, fill 00, blink 00); `tick`=0.
- `run` falling mid-count freezes `cnt`. Rising again resumes from the held value.

## Configuration
- `LED_PATTERN_CTRL_WRAP_EN` defined: `wrap` pulses one cycle, coincident with `tick`, on the advance that returns the pattern to its initial state:
  - bounce: `pos` 1 -> 0;
  - chase: 7 -> 0;
  - fill: 8 -> 0;
  - blink: FF -> 00.
- Not defined: the `wrap` port remains, tied to 0, with no wrap-detect logic.

## Test plan
- Reset with `mode`=0, `run`=1, DEFAULT_DIV=4 -> `led`=80; after 4 cycles `led`=40 with `tick` pulse; the 14-advance sequence ends back at 80, with `wrap`=1 on that advance when the macro is defined.
- `run`=0, 3 `step` pulses in `mode`=2 -> `led` 80, C0, E0; no change between pulses; `step` with `run`=1 has no effect.
- `div_load` with `div_val`=0 -> `div_q`=1; `led` advances every cycle in chase mode: 80, 40, …, 01, 80.
- Mode change 0->3 coincident with a prescaler advance -> `led`=00 next cycle, `tick`=0, `cnt`=0; the next advance after 4 cycles gives FF.
- `reset_n` low mid-fill at `led`=F0 -> `led`=80 immediately, without a clock edge; after release with `mode`=2 held, the restart gives `led`=00.
- `div_load` of 2 while `cnt`=2 -> no advance that cycle; the next advance comes 2 cycles later.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: 8-LED pattern sequencer with programmable tick prescaler,
// run/step control and four pattern modes (bounce, chase, fill, blink).
// Optional feature: define LED_PATTERN_CTRL_WRAP_EN to enable the wrap pulse
// on pattern-cycle completion; otherwise wrap is tied low.
module led_pattern_ctrl #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  output logic [7:0]       led,
  output logic             tick,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  mode_t            mode_q;
  mode_t            mode_in;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [3:0]       pos;
  logic [3:0]       pos_nxt;
  logic [3:0]       pos_adv;
  logic             dir;
  logic             dir_nxt;
  logic             dir_adv;
  logic             restart;
  logic             advance;

  assign mode_in = mode_t'(mode);
  assign restart = (mode_in != mode_q);

  // LED image for a given mode and position
  function automatic logic [7:0] pattern(input mode_t m, input logic [3:0] p);
    logic [7:0] r;
    case (m)
      MODE_FILL:  r = ~(8'hFF >> p);
      MODE_BLINK: r = p[0] ? 8'hFF : 8'h00;
      default:    r = 8'h80 >> p;
    endcase
    return r;
  endfunction

  // Next pattern position/direction if an advance fires this cycle
  always_comb begin
    pos_adv = pos;
    dir_adv = dir;
    case (mode_q)
      MODE_BOUNCE: begin
        if (!dir) begin
          if (pos == 4'd7) begin
            pos_adv = 4'd6;
            dir_adv = 1'b1;
          end else begin
            pos_adv = pos + 4'd1;
          end
        end else begin
          if (pos == 4'd0) begin
            pos_adv = 4'd1;
            dir_adv = 1'b0;
          end else begin
            pos_adv = pos - 4'd1;
          end
        end
      end
      MODE_CHASE: pos_adv = {1'b0, pos[2:0] + 3'd1};
      MODE_FILL:  pos_adv = (pos == 4'd8) ? 4'd0 : pos + 4'd1;
      default:    pos_adv = {3'b000, ~pos[0]};
    endcase
  end

  // Prescaler, advance decision and next pattern state; restart beats
  // div_load, which beats advance
  always_comb begin
    advance = 1'b0;
    cnt_nxt = cnt;
    pos_nxt = pos;
    dir_nxt = dir;
    if (restart) begin
      cnt_nxt = '0;
      pos_nxt = 4'd0;
      dir_nxt = 1'b0;
    end else if (div_load) begin
      cnt_nxt = '0;
    end else if (run) begin
      if (cnt == div_q - 1'b1) begin
        advance = 1'b1;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else if (step) begin
      advance = 1'b1;
    end
    if (advance) begin
      pos_nxt = pos_adv;
      dir_nxt = dir_adv;
    end
  end

`ifdef LED_PATTERN_CTRL_WRAP_EN
  logic wrap_hit;

  // Advance from the last state of the cycle back to the initial state
  always_comb begin
    case (mode_q)
      MODE_BOUNCE: wrap_hit = dir && (pos == 4'd1);
      MODE_CHASE:  wrap_hit = (pos[2:0] == 3'd7);
      MODE_FILL:   wrap_hit = (pos == 4'd8);
      default:     wrap_hit = pos[0];
    endcase
  end

  // Registered wrap pulse, coincident with tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wrap <= 1'b0;
    else          wrap <= advance && wrap_hit;
  end
`else
  assign wrap = 1'b0;
`endif

  // State registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_BOUNCE;
      div_q  <= DIV_W'(DEFAULT_DIV);
      cnt    <= '0;
      pos    <= 4'd0;
      dir    <= 1'b0;
      led    <= 8'h80;
      tick   <= 1'b0;
    end else begin
      mode_q <= mode_in;
      if (div_load)
        div_q <= (div_val == '0) ? DIV_W'(1) : div_val;
      cnt  <= cnt_nxt;
      pos  <= pos_nxt;
      dir  <= dir_nxt;
      led  <= pattern(restart ? mode_in : mode_q, pos_nxt);
      tick <= advance;
    end
  end

endmodule
